// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: dmem request/ack handshake and load formatting
//
// Sits between the execute ALU and writeback; handles one instruction at a time.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   ex_valid / ex_ready            instruction handshake from execute (ready only in IDLE)
//   ex_alu_out, ex_store_data      address-or-result, store source value
//   ex_funct3, ex_mem_read/write   access size/sign and access kind
//   ex_rd, ex_reg_write            destination register and its write enable
//   dmem_req/we/addr/wdata/be      data-memory request, held until dmem_ack
//   dmem_ack, dmem_rdata           memory completion and read word
//   wb_valid, wb_rd, wb_data,      registered writeback record, wb_valid pulses once
//   wb_reg_write                   per retired instruction
//   mem_err                        one-cycle pulse for a rejected memory access
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_reg_write,
  output logic            mem_err
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_q, state_d;
  logic              dmem_req_q, dmem_req_d;
  logic              dmem_we_q, dmem_we_d;
  logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
  logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
  logic [3:0]        dmem_be_q, dmem_be_d;
  logic              wb_valid_q, wb_valid_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]   wb_data_q, wb_data_d;
  logic              wb_reg_write_q, wb_reg_write_d;
  logic              mem_err_q, mem_err_d;
  // Context of the in-flight access, needed to retire it when the ack arrives.
  logic [4:0]        rd_cap_q, rd_cap_d;
  logic [2:0]        f3_cap_q, f3_cap_d;
  logic [1:0]        off_cap_q, off_cap_d;
  logic              rw_cap_q, rw_cap_d;

  logic [1:0]        off;
  logic              is_mem;
  logic              f3_illegal;
  logic              misaligned;
  logic              acc_err;
  logic [3:0]        be_calc;
  logic [XLEN-1:0]   wdata_calc;
  logic [XLEN-1:0]   lane;
  logic [XLEN-1:0]   load_fmt;

  assign off        = ex_alu_out[1:0];
  assign is_mem     = ex_mem_read | ex_mem_write;
  assign f3_illegal = (ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111);
  assign misaligned = ((ex_funct3[1:0] == 2'b01) && off[0]) ||
                      ((ex_funct3[1:0] == 2'b10) && (off != 2'b00));
  assign acc_err    = (ex_mem_read & ex_mem_write) | f3_illegal | misaligned;

  // funct3[1:0] encodes the size for both signed and unsigned variants.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << off;
        wdata_calc = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << off;
        wdata_calc = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed byte/half down to bit 0, then extend.
  assign lane = dmem_rdata >> {off_cap_q, 3'b000};

  always_comb begin
    load_fmt = lane;
    case (f3_cap_q)
      3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_fmt = {24'd0, lane[7:0]};
      3'b101:  load_fmt = {16'd0, lane[15:0]};
      default: load_fmt = lane;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    dmem_req_d     = dmem_req_q;
    dmem_we_d      = dmem_we_q;
    dmem_addr_d    = dmem_addr_q;
    dmem_wdata_d   = dmem_wdata_q;
    dmem_be_d      = dmem_be_q;
    wb_valid_d     = 1'b0;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_reg_write_d = wb_reg_write_q;
    mem_err_d      = 1'b0;
    rd_cap_d       = rd_cap_q;
    f3_cap_d       = f3_cap_q;
    off_cap_d      = off_cap_q;
    rw_cap_d       = rw_cap_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (!is_mem) begin
            wb_valid_d     = 1'b1;
            wb_rd_d        = ex_rd;
            wb_data_d      = ex_alu_out;
            wb_reg_write_d = ex_reg_write & (ex_rd != 5'd0);
          end else if (acc_err) begin
            mem_err_d      = 1'b1;
            wb_valid_d     = 1'b1;
            wb_rd_d        = ex_rd;
            wb_data_d      = '0;
            wb_reg_write_d = 1'b0;
          end else begin
            state_d      = REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = ex_mem_write;
            dmem_addr_d  = {ex_alu_out[XLEN-1:2], 2'b00};
            dmem_be_d    = be_calc;
            dmem_wdata_d = wdata_calc;
            rd_cap_d     = ex_rd;
            f3_cap_d     = ex_funct3;
            off_cap_d    = off;
            rw_cap_d     = ex_reg_write;
          end
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d    = IDLE;
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
          dmem_be_d  = 4'b0000;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_cap_q;
          if (dmem_we_q) begin
            wb_data_d      = '0;
            wb_reg_write_d = 1'b0;
          end else begin
            wb_data_d      = load_fmt;
            wb_reg_write_d = rw_cap_q & (rd_cap_q != 5'd0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      dmem_addr_q    <= '0;
      dmem_wdata_q   <= '0;
      dmem_be_q      <= 4'b0000;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= '0;
      wb_reg_write_q <= 1'b0;
      mem_err_q      <= 1'b0;
      rd_cap_q       <= 5'd0;
      f3_cap_q       <= 3'd0;
      off_cap_q      <= 2'd0;
      rw_cap_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      dmem_addr_q    <= dmem_addr_d;
      dmem_wdata_q   <= dmem_wdata_d;
      dmem_be_q      <= dmem_be_d;
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_reg_write_q <= wb_reg_write_d;
      mem_err_q      <= mem_err_d;
      rd_cap_q       <= rd_cap_d;
      f3_cap_q       <= f3_cap_d;
      off_cap_q      <= off_cap_d;
      rw_cap_q       <= rw_cap_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = dmem_req_q;
  assign dmem_we      = dmem_we_q;
  assign dmem_addr    = dmem_addr_q;
  assign dmem_wdata   = dmem_wdata_q;
  assign dmem_be      = dmem_be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_reg_write = wb_reg_write_q;
  assign mem_err      = mem_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute ALU.
- Consumes the ALU result (effective address or arithmetic result), store data and load/store control for one instruction at a time.
- Runs a request/acknowledge transaction with the data memory and formats load data (byte/half extraction, sign/zero extension).
- Presents one registered writeback record per instruction to the writeback stage.

Parameters:
XLEN, 32, datapath/address width (only 32 supported)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on the rising clk edge
ex_valid  input  1  execute stage presents an instruction
ex_ready  output  1  stage can accept (combinational, high only in IDLE)
ex_alu_out  input  32  ALU result: address for loads/stores, result otherwise
ex_store_data  input  32  rs2 value for stores
ex_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
ex_mem_read  input  1  instruction is a load
ex_mem_write  input  1  instruction is a store
ex_rd  input  5  destination register
ex_reg_write  input  1  instruction writes rd
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  32  word-aligned address {ex_alu_out[31:2],2'b00}
dmem_wdata  output  32  lane-replicated store data
dmem_be  output  4  byte enables
dmem_ack  input  1  memory completes the current request this cycle
dmem_rdata  input  32  read word, valid when dmem_ack=1 on a read
wb_valid  output  1  one-cycle pulse per retired instruction
wb_rd  output  5  destination register
wb_data  output  32  result or formatted load data
wb_reg_write  output  1  register-file write enable
mem_err  output  1  one-cycle pulse: misaligned, illegal funct3, or read+write both set

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data, wb_reg_write and mem_err all become 0.
- Reset mid-transaction: the request is abandoned and dmem_req is low after the reset edge. An ack arriving in IDLE is ignored.
- FSM states: IDLE, REQ.
- ex_ready = (state==IDLE). An accept is ex_valid & ex_ready at a rising edge.
- Accept, non-memory instruction: wb_valid=1 on the next cycle with wb_data=ex_alu_out, wb_rd=ex_rd, wb_reg_write=ex_reg_write & (ex_rd!=0). State stays IDLE, so throughput is 1 instruction per cycle.
- Accept with an error: error cases are mem_read and mem_write both set, illegal funct3, or misaligned access. Misaligned means H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0. No memory request is issued. Next cycle: mem_err=1, wb_valid=1, wb_reg_write=0, wb_data=0. State stays IDLE.
- Accept, legal memory op: next cycle state=REQ and dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata are registered at accept and held stable until ack. Captured rd, funct3 and addr[1:0] are held internally.
- Byte enables and write data (off = addr[1:0]):
  - B: be = 0001<<off, wdata = {4{sd[7:0]}}.
  - H: be = 0011<<off, wdata = {2{sd[15:0]}}.
  - W: be = 1111, wdata = sd.
  - Reads drive be per size as well.
- REQ, dmem_ack=0: hold all outputs (no limit on wait).
- REQ, dmem_ack=1 at an edge: dmem_req, dmem_we and dmem_be go to 0, state returns to IDLE, wb_valid=1 the same cycle.
  - Loads: wb_data = formatted dmem_rdata and wb_reg_write = ex_reg_write_captured & (rd!=0).
  - Stores: wb_reg_write=0 and wb_data=0.
- Load latency: accept edge T, REQ from T. Ack sampled at edge T+k (k≥1) gives wb_valid in the cycle after T+k. The next accept is possible at edge T+k+1.
- Load formatting: lane = dmem_rdata >> (8*off).
  - B: sign-extend lane[7:0]. BU: zero-extend lane[7:0].
  - H: sign-extend lane[15:0]. HU: zero-extend lane[15:0].
  - W: full word.
- wb_valid and mem_err are single-cycle pulses with no backpressure. wb_rd, wb_data and wb_reg_write hold their value until the next retirement.

Test Plan:
- Non-memory pass-through: 3 back-to-back ALU ops, alu_out=0x11,0x22,0x33, rd=5 → three consecutive wb_valid pulses carrying those values, ex_ready constantly 1, dmem_req never high.
- LB sign extend: alu_out=0x1003, funct3=000, rd=7, ack after 3 wait cycles, rdata=0x80FF_0000 → dmem_addr=0x1000, be=1000, ex_ready low 4 cycles, wb_data=0xFFFF_FF80, wb_reg_write=1.
- LHU/LH: alu_out=0x2002, rdata=0x8001_1234, funct3=101 → 0x0000_8001. funct3=001 → 0xFFFF_8001.
- SB/SH/SW: store_data=0xAABB_CCDD. SB@0x3001 → be=0010, wdata=0xDDDD_DDDD. SH@0x3002 → be=1100, wdata=0xCCDD_CCDD. All three: wb_reg_write=0, wb_valid pulse after ack.
- Errors: LW@0x4002, SH@0x4001, funct3=011, read+write set → mem_err pulse each, no dmem_req, wb_reg_write=0. Also rd=0 load → wb_reg_write=0.
- Reset in REQ: assert rst_n=0 while dmem_req=1 → all outputs 0 next cycle. Ack driven 1 cycle later → no wb_valid, state IDLE, ex_ready=1.
